cu_if_prefetch: RTL and testbench

//  Parametrised instruction-fetch front end for the CU. Holds the fetch PC, issues

---
 rtl/cu_if_pkg.sv | 23 ++
 rtl/cu_if_prefetch_if.sv | 25 ++
 rtl/cu_if_fifo.sv | 57 +++++
 rtl/cu_if_prefetch.sv | 147 ++++++++++++++
 tb/tb_cu_if_prefetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_if_pkg.sv
// Shared types and constants for the CU instruction-fetch front end.
package cu_if_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_STEP      = 4;
    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HALT
    } fetch_state_t;

    // One prefetch slot at the default PC width.
    typedef struct packed {
        logic                    fault;
        logic [DEFAULT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/cu_if_prefetch_if.sv
// Memory-side read channel: valid/ready request plus in-order valid response.
interface cu_if_prefetch_if
    import cu_if_pkg::*;
#(
    parameter int XLEN = 32
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_req_we;
    logic [3:0]         mem_req_be;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               mem_rsp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
    );
endinterface

// File: rtl/cu_if_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from storage.
module cu_if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                   soc_clk,
    input  logic                   IF_reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_fire;
    logic             pop_fire;

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign pop_fire  = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign push_fire = push && (!full || pop_fire);
    assign count     = count_reg;
    assign dout      = mem_reg[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge soc_clk or posedge IF_reset) begin
        if (IF_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
        end
    end

    // Entry storage; contents need no reset because outputs are masked by valid.
    always_ff @(posedge soc_clk) begin
        if (push_fire && !flush) mem_reg[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/cu_if_prefetch.sv
// Instruction-fetch front end: fetch PC, one-outstanding read FSM, prefetch FIFO.
module cu_if_prefetch
    import cu_if_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic               soc_clk,
    input  logic               IF_reset,
    input  logic               IF_poweron,
    input  logic               IF_stall,
    input  logic               IF_redirect,
    input  logic [XLEN-1:0]    IF_redirect_pc,
    cu_if_prefetch_if.master   mem,
    output logic               IF_valid,
    output logic [INSTR_W-1:0] IF_data,
    output logic [XLEN-1:0]    IF_pc,
    output logic               IF_fault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 1 + XLEN + INSTR_W;

    typedef struct packed {
        logic               fault;
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] redirect_pc_aligned;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    entry_t          fifo_din;
    entry_t          fifo_head;
    logic [CW:0]     count_after_rsp;
    logic            credit_now;
    logic            credit_after_rsp;
    logic            req_hs;

    assign redirect_pc_aligned = IF_redirect_pc & ~XLEN'(3);
    assign fifo_pop            = !fifo_empty && !IF_stall;
    assign req_hs              = (state_reg == REQ) && mem.mem_req_ready;

    // Credit: no request may be issued unless its response is guaranteed a slot.
    assign credit_now       = !fifo_full;
    assign count_after_rsp  = {1'b0, fifo_count} + (CW+1)'(1) - (CW+1)'(fifo_pop);
    assign credit_after_rsp = count_after_rsp < (CW+1)'(FIFO_DEPTH);

    // Only one request is ever in flight, so its PC is one step behind fetch_pc.
    assign fifo_din.fault = mem.mem_rsp_err;
    assign fifo_din.pc    = fetch_pc_reg - XLEN'(PC_STEP);
    assign fifo_din.instr = mem.mem_rsp_err ? '0 : mem.mem_rsp_data;

    cu_if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .soc_clk  (soc_clk),
        .IF_reset (IF_reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (IF_redirect),
        .din      (fifo_din),
        .dout     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State and fetch PC registers.
    always_ff @(posedge soc_clk or posedge IF_reset) begin
        if (IF_reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // Next-state, PC update and FIFO push; redirect overrides everything else.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        fifo_push     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (IF_poweron && credit_now) state_next = REQ;
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    fifo_push = 1'b1;
                    if (mem.mem_rsp_err)                     state_next = HALT;
                    else if (IF_poweron && credit_after_rsp) state_next = REQ;
                    else                                     state_next = IDLE;
                end
            end
            DRAIN: begin
                if (mem.mem_rsp_valid) begin
                    state_next = (IF_poweron && credit_now) ? REQ : IDLE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (IF_redirect) begin
            fifo_push     = 1'b0;
            fetch_pc_next = redirect_pc_aligned;
            unique case (state_reg)
                // An accepted old request still owes a response that must be dropped.
                REQ:         state_next = req_hs ? DRAIN : REQ;
                WAIT, DRAIN: state_next = mem.mem_rsp_valid ? REQ : DRAIN;
                default:     state_next = REQ;
            endcase
        end
    end

    assign mem.mem_req_valid = (state_reg == REQ);
    assign mem.mem_req_addr  = fetch_pc_reg;
    assign mem.mem_req_we    = 1'b0;
    assign mem.mem_req_be    = 4'b1111;

    // Head fields are forced to zero whenever no entry is present.
    assign IF_valid = !fifo_empty;
    assign IF_data  = IF_valid ? fifo_head.instr : '0;
    assign IF_pc    = IF_valid ? fifo_head.pc    : '0;
    assign IF_fault = IF_valid && fifo_head.fault;

endmodule

// File: tb/tb_cu_if_prefetch.sv
// Randomised scoreboard bench for cu_if_prefetch with a memory responder.
module tb_cu_if_prefetch;
    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        soc_clk = 1'b0;
    logic        IF_reset;
    logic        IF_poweron;
    logic        IF_stall;
    logic        IF_redirect;
    logic [31:0] IF_redirect_pc;
    logic        IF_valid;
    logic [31:0] IF_data;
    logic [31:0] IF_pc;
    logic        IF_fault;

    cu_if_prefetch_if #(.XLEN(XLEN)) mem_bus ();

    cu_if_prefetch #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .soc_clk        (soc_clk),
        .IF_reset       (IF_reset),
        .IF_poweron     (IF_poweron),
        .IF_stall       (IF_stall),
        .IF_redirect    (IF_redirect),
        .IF_redirect_pc (IF_redirect_pc),
        .mem            (mem_bus),
        .IF_valid       (IF_valid),
        .IF_data        (IF_data),
        .IF_pc          (IF_pc),
        .IF_fault       (IF_fault)
    );

    always #5 soc_clk = ~soc_clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- memory contents (shared by responder and model) ----------------
    logic [31:0] fault_pc   = 32'h1;
    bit          rand_fault = 1'b0;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit errfn(input logic [31:0] a);
        return (a == fault_pc) || (rand_fault && (a[8:2] == 7'h25));
    endfunction

    // ---------------- reference model + monitor ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] out_q[$];
    int          stale_cnt;
    logic [31:0] model_pc;
    bit          halted;
    bit          m_hs, m_rsp, m_pop;
    int          m_tot;
    exp_t        m_e;
    logic [31:0] m_pc;

    // Expected fetch stream: sequential PCs from the last restart point, cut at a fault.
    always @(negedge soc_clk) begin
        if (IF_reset) begin
            exp_q.delete();
            out_q.delete();
            stale_cnt = 0;
            model_pc  = RESET_PC;
            halted    = 1'b0;
        end else begin
            check("if_valid", IF_valid, exp_q.size() != 0);
            if (IF_valid && exp_q.size() != 0) begin
                check("if_pc",    IF_pc,    exp_q[0].pc);
                check("if_data",  IF_data,  exp_q[0].instr);
                check("if_fault", IF_fault, exp_q[0].fault);
            end
            if (halted) check("halt_no_req", mem_bus.mem_req_valid, 0);
            if (mem_bus.mem_req_valid) begin
                check("req_addr", mem_bus.mem_req_addr, model_pc);
                check("req_attr", {mem_bus.mem_req_we, mem_bus.mem_req_be}, 5'b0_1111);
            end

            m_hs  = mem_bus.mem_req_valid && mem_bus.mem_req_ready;
            m_rsp = mem_bus.mem_rsp_valid;
            m_pop = IF_valid && !IF_stall;
            if (m_hs) check("credit", exp_q.size() < DEPTH, 1);

            if (IF_redirect) begin
                m_tot = stale_cnt + out_q.size();
                if (m_rsp && m_tot > 0) m_tot--;
                if (m_hs) m_tot++;
                stale_cnt = m_tot;
                out_q.delete();
                exp_q.delete();
                model_pc = IF_redirect_pc & ~32'd3;
                halted   = 1'b0;
            end else begin
                if (m_pop && exp_q.size() != 0) void'(exp_q.pop_front());
                if (m_rsp) begin
                    if (stale_cnt > 0) begin
                        stale_cnt--;
                    end else if (out_q.size() != 0) begin
                        m_pc     = out_q.pop_front();
                        m_e.pc    = m_pc;
                        m_e.fault = errfn(m_pc);
                        m_e.instr = m_e.fault ? 32'h0 : memdata(m_pc);
                        exp_q.push_back(m_e);
                        if (m_e.fault) halted = 1'b1;
                    end
                end
                if (m_hs) begin
                    out_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- stimulus / memory responder ----------------
    int          ready_pct = 100, stall_pct = 0, pow_pct = 100;
    int          lat_min = 0, lat_max = 0;
    bit          redir_req = 1'b0;
    logic [31:0] redir_pc_req = '0;
    bit          stray_req = 1'b0;
    logic [31:0] pend_q[$];
    int          pend_wait = 0;

    task automatic step();
        @(posedge soc_clk);
        #1;
        IF_redirect    = redir_req;
        IF_redirect_pc = redir_pc_req;
        redir_req      = 1'b0;
        mem_bus.mem_req_ready = ($urandom_range(99) < ready_pct);
        IF_stall       = ($urandom_range(99) < stall_pct);
        IF_poweron     = ($urandom_range(99) < pow_pct);
        if (stray_req) begin
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rsp_data  = $urandom;
            mem_bus.mem_rsp_err   = 1'b0;
            stray_req = 1'b0;
        end else if (pend_q.size() != 0 && pend_wait == 0) begin
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rsp_data  = memdata(pend_q[0]);
            mem_bus.mem_rsp_err   = errfn(pend_q[0]);
        end else begin
            mem_bus.mem_rsp_valid = 1'b0;
            mem_bus.mem_rsp_data  = $urandom;
            mem_bus.mem_rsp_err   = $urandom_range(1);
            if (pend_q.size() != 0) pend_wait--;
        end
        @(negedge soc_clk);
        if (IF_reset) begin
            pend_q.delete();
        end else begin
            if (mem_bus.mem_rsp_valid && pend_q.size() != 0) void'(pend_q.pop_front());
            if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
                pend_q.push_back(mem_bus.mem_req_addr);
                pend_wait = $urandom_range(lat_max, lat_min);
            end
        end
    endtask

    task automatic wait_pending(input string name);
        int n = 0;
        while (pend_q.size() == 0 && n < 30) begin
            step();
            n++;
        end
        check(name, pend_q.size() != 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {IF_valid, IF_fault, mem_bus.mem_req_valid}, 0);
        check({tag, "_data"}, {IF_data, IF_pc}, 0);
        check({tag, "_addr"}, mem_bus.mem_req_addr, RESET_PC);
    endtask

    initial begin
        IF_reset       = 1'b1;
        IF_poweron     = 1'b0;
        IF_stall       = 1'b0;
        IF_redirect    = 1'b0;
        IF_redirect_pc = '0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = '0;
        mem_bus.mem_rsp_err   = 1'b0;
        #12;
        check_reset_outputs("reset");
        IF_reset = 1'b0;

        // Streaming fetch with an always-ready, next-cycle memory.
        repeat (20) step();

        // Backpressure: FIFO fills and requests stop.
        stall_pct = 100;
        repeat (10) step();
        check("stall_no_req", mem_bus.mem_req_valid, 0);
        check("stall_head",   IF_valid, 1);
        stall_pct = 0;
        repeat (15) step();

        // Redirect while a response is outstanding.
        lat_min = 3; lat_max = 3;
        wait_pending("wait_before_redirect");
        redir_req = 1'b1; redir_pc_req = 32'h0000_1003;
        step();
        repeat (25) step();

        // Fault at 0x8 halts fetch until redirected to 0x40.
        lat_min = 0; lat_max = 0;
        fault_pc  = 32'h8;
        redir_req = 1'b1; redir_pc_req = 32'h0;
        repeat (20) step();
        check("fault_halt_req", mem_bus.mem_req_valid, 0);
        fault_pc  = 32'h1;
        redir_req = 1'b1; redir_pc_req = 32'h40;
        repeat (15) step();

        // Address wrap at the top of the space.
        redir_req = 1'b1; redir_pc_req = 32'hFFFF_FFF4;
        repeat (16) step();

        // Randomised traffic.
        ready_pct = 70; stall_pct = 30; pow_pct = 90;
        lat_min = 0; lat_max = 3; rand_fault = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) begin
                redir_req    = 1'b1;
                redir_pc_req = $urandom_range(32'h3FF);
            end
            step();
        end

        // Reset in the middle of an outstanding read.
        ready_pct = 100; stall_pct = 0; pow_pct = 100; rand_fault = 1'b0;
        lat_min = 5; lat_max = 5;
        redir_req = 1'b1; redir_pc_req = 32'h200;
        repeat (3) step();
        wait_pending("wait_before_reset");
        @(posedge soc_clk);
        #3 IF_reset = 1'b1;
        #1 check_reset_outputs("midreset");
        pow_pct = 0;
        step();
        step();
        #2 IF_reset = 1'b0;
        stray_req = 1'b1;
        step();
        repeat (3) step();
        check("poweroff_no_req", mem_bus.mem_req_valid, 0);
        pow_pct = 100; lat_min = 0; lat_max = 1;
        repeat (30) step();

        // Power off and let the FIFO drain.
        pow_pct = 0;
        repeat (20) step();
        check("drained", IF_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
